fdiv_arb: RTL and testbench
===========================

# fdiv_arb

Shared-access controller for the single-precision `fdiv` unit. It arbitrates round-robin between `NREQ` requesters and registers the chosen operands onto the combinational `fdiv` datapath. It holds those operands stable for `LAT` cycles, a multicycle path, then captures `y`/`ovf` and returns them with the requester ID over a valid/ready handshake. It sits between the FPU issue ports and the one `fdiv` instance, allowing one outstanding operation.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `LAT`, 3: cycles operands are held on `fdiv` before capture (≥1).
- `IDW`, derived as max(1, $clog2(NREQ)): width of the ID field.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: synchronous active-low reset.
- `req_valid` in NREQ: request from requester i.
- `req_x1` in 32*NREQ: dividend of requester i, at bits [32i+31:32i].
- `req_x2` in 32*NREQ: divisor of requester i, same packing.
- `req_ready` out NREQ: one-hot grant; asserted only in IDLE.
- `resp_valid` out 1: result available.
- `resp_id` out IDW: index of the requester that owns the result.
- `resp_y` out 32: quotient captured from `fdiv`.
- `resp_ovf` out 1: overflow captured from `fdiv`.
- `resp_ready` in 1: consumer accepts the result.
- `busy` out 1: high in BUSY and DONE.
- `ovf_sticky` out 1: accumulated overflow flag.
- `ovf_clr` in 1: clears `ovf_sticky`.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - Grant goes to the first asserted `req_valid` at or after `ptr`, searching upward modulo NREQ.
  - `req_ready` is driven combinationally and is one-hot on the granted index; it is all-zero if there are no requests.
  - On `req_valid[g] & req_ready[g]`:
    - latch `req_x1`/`req_x2` slice g into `op_x1`/`op_x2`;
    - latch g into `id_q`;
    - load `cnt = LAT-1`;
    - set `ptr = (g+1) mod NREQ`;
    - go to BUSY.
- **BUSY:**
  - `op_x1`/`op_x2` drive `fdiv` directly and stay unchanged.
  - If `cnt != 0`, decrement it.
  - If `cnt == 0`, capture `fdiv` `y`/`ovf` into `resp_y`/`resp_ovf`, drive `resp_id = id_q`, and go to DONE.
- **DONE:**
  - `resp_valid = 1`; all response outputs are held stable.
  - On `resp_ready`, go to IDLE.
  - No request is accepted in DONE or BUSY.
- **Sticky overflow:** `ovf_sticky` sets on a capture with `ovf = 1` and clears on `ovf_clr`. A simultaneous set and clear leaves it set.
- **Withdrawn requests:** a requester may drop `req_valid` before acceptance; it is then not granted.
- **Pointer fairness:** `ptr` advances only on an accepted request. With all requesters always valid, grants cycle 0, 1, …, NREQ-1.

## Timing
- **Reset** (`rstn = 0` at a rising edge): state IDLE, `ptr = 0`, `cnt = 0`. All outputs are 0: `req_ready`, `resp_valid`, `resp_id`, `resp_y`, `resp_ovf`, `busy`, `ovf_sticky`, and `op_x1`/`op_x2`.
- **Reset mid-operation:** the in-flight operation is discarded with no response, and the next cycle is IDLE.
- **Latency:** accept at edge k; `resp_valid` is first high in the cycle after edge k+LAT.
- **Throughput:** with `resp_ready` held high, the minimum issue interval is LAT+2 cycles. Response handshake at edge k+LAT+1 gives IDLE, and the next accept is at edge k+LAT+2.
- **Multicycle path:** the path `op_x*` → `fdiv` → result regs is a LAT-cycle constraint. `op_x*` are written only in IDLE on accept.
- **Backpressure:** `resp_ready` low holds DONE indefinitely, with outputs constant and `req_ready` all-zero.
- **LAT = 1:** capture happens at the first BUSY edge.

## Configuration
- **Macro:** `FDIV_ARB_OVF_EN`.
- **Defined:** `resp_ovf` and `ovf_sticky`/`ovf_clr` behave as described above.
- **Undefined:**
  - `fdiv` `ovf` is ignored.
  - `resp_ovf` and `ovf_sticky` are tied 0.
  - `ovf_clr` is unused.
  - The sticky register is not synthesized.
  - The port list is unchanged.

## Test plan
- **Basic divide:** NREQ=2, LAT=3; requester 0 sends 0x40C00000 / 0x40000000. Expect `resp_valid` 3 cycles after accept, `resp_y = 0x40400000`, `resp_id = 0`, `resp_ovf = 0`.
- **Round-robin:** both requesters hold `req_valid` continuously (r0: 0x3F800000/0x40400000, r1: 0x41200000/0x40A00000) with `resp_ready = 1`. Expect grants 0,1,0,1, each accept LAT+2 = 5 cycles apart. r0 → y equals the `fdiv` combinational output for those operands; r1 → 0x40000000.
- **Overflow** (macro defined): 0x7F000000 / 0x00800000. Expect `resp_ovf = 1` and `ovf_sticky` = 1. Then pulse `ovf_clr` together with a new overflowing capture; expect sticky to stay 1. A later `ovf_clr` alone → 0. With the macro undefined, both outputs stay 0.
- **Backpressure:** hold `resp_ready = 0` for 6 cycles in DONE. Expect `resp_*` stable and `req_ready = 0` despite `req_valid = 2'b11`. On release, return to IDLE next cycle.
- **Reset mid-operation:** assert `rstn = 0` during BUSY. Expect all outputs 0 after the edge, no `resp_valid` for the dropped op, and `ptr = 0` so requester 0 is granted first.
- **LAT=1 corner:** 0xC0800000 / 0x40000000. Expect `resp_valid` 1 cycle after accept with `resp_y = 0xC0000000`.

Source files
------------

// File: rtl/fdiv_arb.sv
// Round-robin shared-access controller for one combinational single-precision divider (fdiv).
// Optional overflow reporting (resp_ovf, ovf_sticky, ovf_clr) is enabled by defining FDIV_ARB_OVF_EN.

module fdiv (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);
    logic               sgn;
    logic [7:0]         e1;
    logic [7:0]         e2;
    logic [23:0]        m1;
    logic [23:0]        m2;
    logic [25:0]        q;
    logic [24:0]        rem;
    logic [23:0]        mant;
    logic               grd;
    logic               stk;
    logic [24:0]        mant_r;
    logic [22:0]        frac;
    logic signed [10:0] exp_c;
    logic               zero1;
    logic               zero2;
    logic               inf1;
    logic               inf2;
    logic               nan1;
    logic               nan2;

    function automatic logic [24:0] round_ne(input logic [23:0] m, input logic g, input logic s);
        return {1'b0, m} + {24'b0, g & (s | m[0])};
    endfunction

    always_comb begin
        sgn   = x1[31] ^ x2[31];
        e1    = x1[30:23];
        e2    = x2[30:23];
        m1    = {1'b1, x1[22:0]};
        m2    = {1'b1, x2[22:0]};
        zero1 = (e1 == 8'h00);
        zero2 = (e2 == 8'h00);
        inf1  = (e1 == 8'hFF) && (x1[22:0] == '0);
        inf2  = (e2 == 8'hFF) && (x2[22:0] == '0);
        nan1  = (e1 == 8'hFF) && (x1[22:0] != '0);
        nan2  = (e2 == 8'hFF) && (x2[22:0] != '0);

        // Restoring division of the 24-bit significands: 26 quotient bits cover [0.5, 2).
        q   = '0;
        rem = {1'b0, m1};
        for (int i = 25; i >= 0; i--) begin
            if (rem >= {1'b0, m2}) begin
                q[i] = 1'b1;
                rem  = rem - {1'b0, m2};
            end
            rem = rem << 1;
        end

        exp_c = $signed({3'b000, e1}) - $signed({3'b000, e2}) + 11'sd127;
        if (q[25]) begin
            mant = q[25:2];
            grd  = q[1];
            stk  = q[0] | (rem != '0);
        end else begin
            mant  = q[24:1];
            grd   = q[0];
            stk   = (rem != '0);
            exp_c = exp_c - 11'sd1;
        end

        mant_r = round_ne(mant, grd, stk);
        if (mant_r[24]) begin
            exp_c = exp_c + 11'sd1;
            frac  = mant_r[23:1];
        end else begin
            frac  = mant_r[22:0];
        end

        ovf = 1'b0;
        y   = {sgn, exp_c[7:0], frac};
        // Subnormal inputs and results are flushed to zero.
        if (nan1 || nan2 || (inf1 && inf2) || (zero1 && zero2)) begin
            y = 32'h7FC0_0000;
        end else if (inf1 || zero2) begin
            y = {sgn, 8'hFF, 23'b0};
        end else if (zero1 || inf2) begin
            y = {sgn, 31'b0};
        end else if (exp_c >= 11'sd255) begin
            y   = {sgn, 8'hFF, 23'b0};
            ovf = 1'b1;
        end else if (exp_c <= 11'sd0) begin
            y = {sgn, 31'b0};
        end
    end
endmodule

module fdiv_arb #(
    parameter int  NREQ = 2,
    parameter int  LAT  = 3,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [32*NREQ-1:0] req_x1,
    input  logic [32*NREQ-1:0] req_x2,
    output logic [NREQ-1:0]    req_ready,
    output logic               resp_valid,
    output logic [IDW-1:0]     resp_id,
    output logic [31:0]        resp_y,
    output logic               resp_ovf,
    input  logic               resp_ready,
    output logic               busy,
    output logic               ovf_sticky,
    input  logic               ovf_clr
);
    localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [31:0]     op_x1_q, op_x1_d;
    logic [31:0]     op_x2_q, op_x2_d;
    logic [31:0]     resp_y_q, resp_y_d;
    logic            resp_ovf_q, resp_ovf_d;

    logic            gnt_vld;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand;
    logic            capture;
    logic [31:0]     fdiv_y;
    logic            fdiv_ovf;
    logic            ovf_cap;

    function automatic logic [IDW-1:0] wrap_idx(input int v);
        int w;
        w = v % NREQ;
        return w[IDW-1:0];
    endfunction

    // Operands stay on the divider for LAT cycles; the result path is a multicycle path.
    fdiv u_fdiv (
        .x1  (op_x1_q),
        .x2  (op_x2_q),
        .y   (fdiv_y),
        .ovf (fdiv_ovf)
    );

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_idx(int'(ptr_q) + k);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign capture = (state_q == BUSY) && (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        op_x1_d    = op_x1_q;
        op_x2_d    = op_x2_q;
        resp_y_d   = resp_y_q;
        resp_ovf_d = resp_ovf_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    op_x1_d = req_x1[32*int'(gnt_idx) +: 32];
                    op_x2_d = req_x2[32*int'(gnt_idx) +: 32];
                    id_d    = gnt_idx;
                    cnt_d   = CNTW'(LAT - 1);
                    ptr_d   = wrap_idx(int'(gnt_idx) + 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (capture) begin
                    resp_y_d   = fdiv_y;
                    resp_ovf_d = ovf_cap;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            id_q       <= '0;
            op_x1_q    <= '0;
            op_x2_q    <= '0;
            resp_y_q   <= '0;
            resp_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            op_x1_q    <= op_x1_d;
            op_x2_q    <= op_x2_d;
            resp_y_q   <= resp_y_d;
            resp_ovf_q <= resp_ovf_d;
        end
    end

`ifdef FDIV_ARB_OVF_EN
    logic ovf_sticky_q, ovf_sticky_d;

    // A capture with overflow wins over a simultaneous clear.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (capture && fdiv_ovf) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_cap    = fdiv_ovf;
    assign ovf_sticky = ovf_sticky_q;
`else
    logic unused_ovf;

    assign unused_ovf = fdiv_ovf ^ ovf_clr;
    assign ovf_cap    = 1'b0;
    assign ovf_sticky = 1'b0;
`endif

    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign resp_id    = id_q;
    assign resp_y     = resp_y_q;
    assign resp_ovf   = resp_ovf_q;
endmodule

// File: tb/tb_fdiv_arb.sv
// Directed bench for fdiv_arb: main instance NREQ=2/LAT=3, second instance NREQ=2/LAT=1.
module tb_fdiv_arb;
    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [63:0] req_x1;
    logic [63:0] req_x2;
    logic [1:0]  req_ready;
    logic        resp_valid;
    logic [0:0]  resp_id;
    logic [31:0] resp_y;
    logic        resp_ovf;
    logic        resp_ready;
    logic        busy;
    logic        ovf_sticky;
    logic        ovf_clr;

    logic [1:0]  d1_req_valid;
    logic [63:0] d1_req_x1;
    logic [63:0] d1_req_x2;
    logic [1:0]  d1_req_ready;
    logic        d1_resp_valid;
    logic [0:0]  d1_resp_id;
    logic [31:0] d1_resp_y;
    logic        d1_resp_ovf;
    logic        d1_resp_ready;
    logic        d1_busy;
    logic        d1_ovf_sticky;
    logic        d1_ovf_clr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

`ifdef FDIV_ARB_OVF_EN
    localparam logic [31:0] OVF_EXP = 32'd1;
`else
    localparam logic [31:0] OVF_EXP = 32'd0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fdiv_arb #(.NREQ(2), .LAT(3)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y),
        .resp_ovf(resp_ovf), .resp_ready(resp_ready), .busy(busy), .ovf_sticky(ovf_sticky),
        .ovf_clr(ovf_clr)
    );

    fdiv_arb #(.NREQ(2), .LAT(1)) dut1 (
        .clk(clk), .rstn(rstn), .req_valid(d1_req_valid), .req_x1(d1_req_x1), .req_x2(d1_req_x2),
        .req_ready(d1_req_ready), .resp_valid(d1_resp_valid), .resp_id(d1_resp_id),
        .resp_y(d1_resp_y), .resp_ovf(d1_resp_ovf), .resp_ready(d1_resp_ready), .busy(d1_busy),
        .ovf_sticky(d1_ovf_sticky), .ovf_clr(d1_ovf_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        check_val("resp_timeout", 32'(resp_valid), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int t_prev;
        logic seen;

        rstn = 1'b0; req_valid = '0; req_x1 = '0; req_x2 = '0; resp_ready = 1'b0; ovf_clr = 1'b0;
        d1_req_valid = '0; d1_req_x1 = '0; d1_req_x2 = '0; d1_resp_ready = 1'b0; d1_ovf_clr = 1'b0;
        t_prev = 0;
        tick();
        tick();
        rstn = 1'b1;

        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_id", 32'(resp_id), 32'd0);
        check_val("rst_resp_y", resp_y, 32'd0);
        check_val("rst_resp_ovf", 32'(resp_ovf), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);

        // Basic divide: 6.0 / 2.0 from requester 0
        req_x1[31:0] = 32'h40C0_0000; req_x2[31:0] = 32'h4000_0000; req_valid = 2'b01;
        #1;
        check_val("basic_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        check_val("basic_busy", 32'(busy), 32'd1);
        wait_resp(n);
        check_val("basic_latency", 32'(n), 32'd3);
        check_val("basic_y", resp_y, 32'h4040_0000);
        check_val("basic_id", 32'(resp_id), 32'd0);
        check_val("basic_ovf", 32'(resp_ovf), 32'd0);
        resp_ready = 1'b1;
        tick();
        check_val("basic_release_valid", 32'(resp_valid), 32'd0);
        check_val("basic_release_busy", 32'(busy), 32'd0);
        resp_ready = 1'b0;

        // Backpressure: pointer now at 1, so requester 1 (10.0 / 5.0) wins
        req_x1[63:32] = 32'h4120_0000; req_x2[63:32] = 32'h40A0_0000; req_valid = 2'b11;
        #1;
        check_val("bp_grant", 32'(req_ready), 32'd2);
        tick();
        wait_resp(n);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("bp_valid", 32'(resp_valid), 32'd1);
            check_val("bp_y", resp_y, 32'h4000_0000);
            check_val("bp_id", 32'(resp_id), 32'd1);
            check_val("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        check_val("bp_idle_busy", 32'(busy), 32'd0);
        check_val("bp_idle_grant", 32'(req_ready), 32'd1);
        req_valid = 2'b00;

        // Reset while BUSY
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        check_val("mid_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_valid", 32'(resp_valid), 32'd0);
        check_val("mid_rst_y", resp_y, 32'd0);
        check_val("mid_rst_id", 32'(resp_id), 32'd0);
        check_val("mid_rst_req_ready", 32'(req_ready), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | resp_valid;
        end
        check_val("mid_no_resp", 32'(seen), 32'd0);

        // Round-robin: r0 = 1.0/3.0, r1 = 10.0/5.0, both always valid
        req_x1[31:0] = 32'h3F80_0000; req_x2[31:0] = 32'h4040_0000;
        req_x1[63:32] = 32'h4120_0000; req_x2[63:32] = 32'h40A0_0000;
        req_valid = 2'b11; resp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin
                tick();
                n++;
            end
            check_val("rr_grant", 32'(req_ready), (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i > 0) check_val("rr_interval", 32'(cyc - t_prev), 32'd5);
            t_prev = cyc;
            tick();
            wait_resp(n);
            check_val("rr_id", 32'(resp_id), 32'(i % 2));
            check_val("rr_y", resp_y, (i % 2 == 1) ? 32'h4000_0000 : 32'h3EAA_AAAB);
        end
        req_valid = 2'b00;
        tick();

        // Overflow: 2^127 / 2^-126
        req_x1[31:0] = 32'h7F00_0000; req_x2[31:0] = 32'h0080_0000; req_valid = 2'b01;
        resp_ready = 1'b0;
        #1;
        tick();
        req_valid = 2'b00;
        wait_resp(n);
        check_val("ovf_resp", 32'(resp_ovf), OVF_EXP);
        check_val("ovf_y", resp_y, 32'h7F80_0000);
        check_val("ovf_sticky_set", 32'(ovf_sticky), OVF_EXP);
        resp_ready = 1'b1;
        tick();
        req_valid = 2'b01; ovf_clr = 1'b1;
        #1;
        tick();
        req_valid = 2'b00;
        wait_resp(n);
        ovf_clr = 1'b0;
        check_val("ovf_set_beats_clr", 32'(ovf_sticky), OVF_EXP);
        tick();
        check_val("ovf_sticky_hold", 32'(ovf_sticky), OVF_EXP);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("ovf_sticky_clr", 32'(ovf_sticky), 32'd0);

        // LAT=1 instance: -4.0 / 2.0
        d1_req_x1[31:0] = 32'hC080_0000; d1_req_x2[31:0] = 32'h4000_0000; d1_req_valid = 2'b01;
        #1;
        check_val("lat1_grant", 32'(d1_req_ready), 32'd1);
        tick();
        d1_req_valid = 2'b00;
        n = 0;
        while (!d1_resp_valid && n < 20) begin
            tick();
            n++;
        end
        check_val("lat1_latency", 32'(n), 32'd1);
        check_val("lat1_y", d1_resp_y, 32'hC000_0000);
        check_val("lat1_id", 32'(d1_resp_id), 32'd0);
        check_val("lat1_ovf", 32'(d1_resp_ovf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
